// File: rtl/fp_execute_stage3.sv
// Third floating point / integer multiply pipeline stage: per-lane extended
// significand add/subtract, leading zero count of the raw sum, and one-cycle
// forwarding of the multiply path and special-case flags.

package fp_execute_stage3_pkg;
    typedef logic [1:0] local_thread_idx_t;
    typedef logic [3:0] subcycle_t;

    typedef enum logic {
        PIPE_MEM = 1'b0,
        PIPE_INT = 1'b1
    } pipeline_sel_t;

    typedef struct packed {
        logic [5:0]  alu_op;
        logic [4:0]  dest_reg;
        logic        dest_is_vector;
        logic        has_dest;
        logic [18:0] immediate;
    } decoded_instruction_t;
endpackage

module fp_execute_stage3
    import fp_execute_stage3_pkg::*;
#(
    parameter int NUM_VECTOR_LANES = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  wb_rollback_en,
    input  local_thread_idx_t                     wb_rollback_thread_idx,
    input  pipeline_sel_t                         wb_rollback_pipeline,
    input  logic                                  fx2_instruction_valid,
    input  decoded_instruction_t                  fx2_instruction,
    input  logic [NUM_VECTOR_LANES-1:0]           fx2_mask_value,
    input  local_thread_idx_t                     fx2_thread_idx,
    input  subcycle_t                             fx2_subcycle,
    input  logic [NUM_VECTOR_LANES-1:0]           fx2_result_is_inf,
    input  logic [NUM_VECTOR_LANES-1:0]           fx2_result_is_nan,
    input  logic [NUM_VECTOR_LANES-1:0][5:0]      fx2_ftoi_lshift,
    input  logic [NUM_VECTOR_LANES-1:0]           fx2_logical_subtract,
    input  logic [NUM_VECTOR_LANES-1:0]           fx2_add_result_sign,
    input  logic [NUM_VECTOR_LANES-1:0][31:0]     fx2_significand_le,
    input  logic [NUM_VECTOR_LANES-1:0][31:0]     fx2_significand_se,
    input  logic [NUM_VECTOR_LANES-1:0][7:0]      fx2_add_exponent,
    input  logic [NUM_VECTOR_LANES-1:0]           fx2_guard,
    input  logic [NUM_VECTOR_LANES-1:0]           fx2_round,
    input  logic [NUM_VECTOR_LANES-1:0]           fx2_sticky,
    input  logic [NUM_VECTOR_LANES-1:0][63:0]     fx2_significand_product,
    input  logic [NUM_VECTOR_LANES-1:0][7:0]      fx2_mul_exponent,
    input  logic [NUM_VECTOR_LANES-1:0]           fx2_mul_sign,
    output logic                                  fx3_instruction_valid,
    output decoded_instruction_t                  fx3_instruction,
    output logic [NUM_VECTOR_LANES-1:0]           fx3_mask_value,
    output local_thread_idx_t                     fx3_thread_idx,
    output subcycle_t                             fx3_subcycle,
    output logic [NUM_VECTOR_LANES-1:0]           fx3_result_is_inf,
    output logic [NUM_VECTOR_LANES-1:0]           fx3_result_is_nan,
    output logic [NUM_VECTOR_LANES-1:0][5:0]      fx3_ftoi_lshift,
    output logic [NUM_VECTOR_LANES-1:0]           fx3_add_result_sign,
    output logic [NUM_VECTOR_LANES-1:0]           fx3_logical_subtract,
    output logic [NUM_VECTOR_LANES-1:0][31:0]     fx3_add_significand,
    output logic [NUM_VECTOR_LANES-1:0][7:0]      fx3_add_exponent,
    output logic [NUM_VECTOR_LANES-1:0]           fx3_guard,
    output logic [NUM_VECTOR_LANES-1:0]           fx3_round,
    output logic [NUM_VECTOR_LANES-1:0]           fx3_sticky,
    output logic [NUM_VECTOR_LANES-1:0]           fx3_add_carry,
    output logic [NUM_VECTOR_LANES-1:0][5:0]      fx3_leading_zeroes,
    output logic [NUM_VECTOR_LANES-1:0][63:0]     fx3_significand_product,
    output logic [NUM_VECTOR_LANES-1:0][7:0]      fx3_mul_exponent,
    output logic [NUM_VECTOR_LANES-1:0]           fx3_mul_sign
);

    // Add or subtract the 35-bit guard/round/sticky-extended significands.
    // Bit 35 is the add carry; subtraction never produces one because the
    // larger-exponent operand is guaranteed not to be smaller.
    function automatic logic [35:0] extended_add(
        input logic [31:0] le,
        input logic [31:0] se,
        input logic [2:0]  grs,
        input logic        subtract
    );
        logic [34:0] a;
        logic [34:0] b;
        a = {le, 3'b000};
        b = {se, grs};
        if (subtract)
            return {1'b0, a + ~b + 35'd1};
        else
            return {1'b0, a} + {1'b0, b};
    endfunction

    // Leading zero count of the 32-bit significand field; 32 when it is zero.
    // The highest set bit is scanned last so it determines the result.
    function automatic logic [5:0] count_leading_zeroes(input logic [31:0] value);
        logic [5:0] count;
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i])
                count = 6'(31 - i);
        end
        return count;
    endfunction

    logic [NUM_VECTOR_LANES-1:0][35:0] sum_p0;
    logic [NUM_VECTOR_LANES-1:0][5:0]  lzc_p0;
    logic                              squash_p0;

    // Per-lane sum and normalization count; every lane is evaluated regardless of mask or op
    always_comb begin
        sum_p0 = '0;
        lzc_p0 = '0;
        for (int lane = 0; lane < NUM_VECTOR_LANES; lane++) begin
            sum_p0[lane] = extended_add(fx2_significand_le[lane], fx2_significand_se[lane],
                                        {fx2_guard[lane], fx2_round[lane], fx2_sticky[lane]},
                                        fx2_logical_subtract[lane]);
            lzc_p0[lane] = count_leading_zeroes(sum_p0[lane][34:3]);
        end
    end

    // Only a memory-pipeline rollback of the incoming thread squashes it here
    assign squash_p0 = wb_rollback_en
                       && (wb_rollback_thread_idx == fx2_thread_idx)
                       && (wb_rollback_pipeline == PIPE_MEM);

    // ---- stage boundary: fx2 -> fx3 ----

    // Instruction valid is the only reset state in this stage
    always_ff @(posedge clk) begin
        if (reset)
            fx3_instruction_valid <= 1'b0;
        else
            fx3_instruction_valid <= fx2_instruction_valid && !squash_p0;
    end

    // Datapath register: add results plus unchanged forwarding of everything else
    always_ff @(posedge clk) begin
        fx3_instruction      <= fx2_instruction;
        fx3_mask_value       <= fx2_mask_value;
        fx3_thread_idx       <= fx2_thread_idx;
        fx3_subcycle         <= fx2_subcycle;
        fx3_result_is_inf    <= fx2_result_is_inf;
        fx3_result_is_nan    <= fx2_result_is_nan;
        fx3_ftoi_lshift      <= fx2_ftoi_lshift;
        fx3_add_result_sign  <= fx2_add_result_sign;
        fx3_logical_subtract <= fx2_logical_subtract;
        fx3_add_exponent     <= fx2_add_exponent;
        fx3_significand_product <= fx2_significand_product;
        fx3_mul_exponent     <= fx2_mul_exponent;
        fx3_mul_sign         <= fx2_mul_sign;
        for (int lane = 0; lane < NUM_VECTOR_LANES; lane++) begin
            fx3_add_significand[lane] <= sum_p0[lane][34:3];
            fx3_guard[lane]           <= sum_p0[lane][2];
            fx3_round[lane]           <= sum_p0[lane][1];
            fx3_sticky[lane]          <= sum_p0[lane][0];
            fx3_add_carry[lane]       <= sum_p0[lane][35];
            fx3_leading_zeroes[lane]  <= lzc_p0[lane];
        end
    end

endmodule
